// File: rtl/ifetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_bridge
// Purpose  : Single-outstanding SRAM-like instruction fetch bridge feeding IF.
//            Optional kseg0/kseg1 address folding: define IFETCH_KSEG_MAP_EN.
// Revision : 1.0  initial release
// ============================================================================
module ifetch_bridge #(
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        advance,
    input  logic        flush,
    output logic        complete,
    output logic [31:0] icache_inst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_cancel;
    logic        w_cancel_nxt;
    logic [31:0] r_inst_buf;
    logic [31:0] w_inst_buf_nxt;
    logic [31:0] r_inst_addr;
    logic [31:0] w_inst_addr_nxt;
    logic [31:0] w_launch_addr;

`ifdef IFETCH_KSEG_MAP_EN
    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    assign w_launch_addr = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;
`else
    assign w_launch_addr = pc;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_cancel    <= 1'b0;
            r_inst_buf  <= 32'h0000_0000;
            r_inst_addr <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_cancel    <= w_cancel_nxt;
            r_inst_buf  <= w_inst_buf_nxt;
            r_inst_addr <= w_inst_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cancel_nxt    = r_cancel;
        w_inst_buf_nxt  = r_inst_buf;
        w_inst_addr_nxt = r_inst_addr;
        case (r_state)
            c_IDLE: begin
                if (fetch_en && !flush) begin
                    if (pc[1:0] == 2'b00) begin
                        w_inst_addr_nxt = w_launch_addr;
                        w_state_nxt     = c_REQ;
                    end else begin
                        w_inst_buf_nxt  = BUBBLE_INST;
                        w_state_nxt     = c_DONE;
                    end
                end
            end
            c_REQ: begin
                // The request stays up even when flushed; the data is dropped later
                if (flush) begin
                    w_cancel_nxt = 1'b1;
                end
                if (inst_addr_ok) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (inst_data_ok) begin
                    if (!r_cancel && !flush) begin
                        w_inst_buf_nxt = inst_rdata;
                        w_state_nxt    = c_DONE;
                    end else begin
                        w_cancel_nxt   = 1'b0;
                        w_state_nxt    = c_IDLE;
                    end
                end else if (flush) begin
                    w_cancel_nxt = 1'b1;
                end
            end
            c_DONE: begin
                if (advance || flush) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        complete = 1'b0;
        inst_req = 1'b0;
        case (r_state)
            c_REQ:   inst_req = 1'b1;
            c_DONE:  complete = 1'b1;
            default: begin
                complete = 1'b0;
                inst_req = 1'b0;
            end
        endcase
    end

    assign icache_inst = r_inst_buf;
    assign inst_addr   = r_inst_addr;
    assign inst_wr     = 1'b0;
    assign inst_size   = 2'b10;
    assign inst_wdata  = 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ifetch_bridge
// Purpose  : Directed and randomized check of ifetch_bridge against a
//            transaction-level fetch model and a behavioural bus slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_bridge;

    localparam logic [31:0] c_BUBBLE = 32'h0000_0000;
`ifdef IFETCH_KSEG_MAP_EN
    localparam logic [31:0] c_ADDR0 = 32'h1fc0_0000;
    localparam logic [31:0] c_ADDR4 = 32'h1fc0_0004;
`else
    localparam logic [31:0] c_ADDR0 = 32'hbfc0_0000;
    localparam logic [31:0] c_ADDR4 = 32'hbfc0_0004;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pc = '0;
    logic        fetch_en = 1'b0;
    logic        advance = 1'b0;
    logic        flush = 1'b0;
    logic        complete;
    logic [31:0] icache_inst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    ifetch_bridge #(.BUBBLE_INST(c_BUBBLE)) dut (
        .clk(clk), .resetn(resetn), .pc(pc), .fetch_en(fetch_en),
        .advance(advance), .flush(flush), .complete(complete),
        .icache_inst(icache_inst), .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Fetch model: what the IF stage should observe, tracked per transaction
    bit          m_busy_addr, m_busy_data, m_holding, m_doomed;
    logic [31:0] m_addr, m_inst;

    // Bus slave
    bit          s_out;
    int          s_delay, s_ddelay, data_lat;
    logic [31:0] s_addr;
    bit          rnd_lat = 1'b0;
    bit          rdata_ovr = 1'b0;
    logic [31:0] rdata_val = '0;

    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef IFETCH_KSEG_MAP_EN
        if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
        return a;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[28:0])
            29'h1fc0_0000: return 32'h3c08_0001;
            29'h1fc0_0004: return 32'h2409_0002;
            29'h1fc0_0380: return 32'h8c0a_0000;
            default:       return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_addr = 0; m_busy_data = 0; m_holding = 0; m_doomed = 0;
        m_addr = '0; m_inst = '0;
        s_out = 0; s_delay = 0; s_ddelay = 0;
    endtask

    task automatic model_step();
        if (m_holding) begin
            if (advance || flush) m_holding = 0;
        end else if (m_busy_addr) begin
            if (flush) m_doomed = 1;
            if (inst_addr_ok) begin
                m_busy_addr = 0;
                m_busy_data = 1;
            end
        end else if (m_busy_data) begin
            if (inst_data_ok) begin
                m_busy_data = 0;
                if (!(m_doomed || flush)) begin
                    m_holding = 1;
                    m_inst = inst_rdata;
                end
                m_doomed = 0;
            end else if (flush) begin
                m_doomed = 1;
            end
        end else if (fetch_en && !flush) begin
            if (pc % 4 == 0) begin
                m_busy_addr = 1;
                m_addr = map_addr(pc);
            end else begin
                m_holding = 1;
                m_inst = c_BUBBLE;
            end
        end
    endtask

    task automatic drive_slave();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        if (m_busy_addr && !s_out) begin
            if (s_delay == 0) begin
                inst_addr_ok = 1'b1;
                s_addr = m_addr;
            end else begin
                s_delay--;
            end
        end
        if (s_out) begin
            if (s_ddelay == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata = rdata_ovr ? rdata_val : mem_word(s_addr);
            end else begin
                s_ddelay--;
            end
        end else if (rnd_lat && !m_busy_data && $urandom_range(9) == 0) begin
            // stray data_ok outside a data phase must be ignored
            inst_data_ok = 1'b1;
        end
    endtask

    task automatic tick();
        drive_slave();
        @(posedge clk);
        model_step();
        if (inst_data_ok && s_out) begin
            s_out = 0;
            s_delay = rnd_lat ? int'($urandom_range(3)) : 0;
        end
        if (inst_addr_ok) begin
            s_out = 1;
            s_ddelay = rnd_lat ? int'($urandom_range(3)) : data_lat;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_until_done(input string nm, input int lim);
        int i;
        i = 0;
        while (!m_holding && i < lim) begin
            tick();
            i++;
        end
        if (!m_holding) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no completion within %0d cycles", nm, lim);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("complete", {31'b0, complete}, {31'b0, m_holding});
            chk("inst_req", {31'b0, inst_req}, {31'b0, m_busy_addr});
            chk("inst_addr", inst_addr, m_addr);
            chk("icache_inst", icache_inst, m_inst);
            chk("inst_wr", {31'b0, inst_wr}, 32'd0);
            chk("inst_size", {30'b0, inst_size}, 32'd2);
            chk("inst_wdata", inst_wdata, 32'd0);
        end
    end

    initial begin
        model_reset();
        data_lat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_complete", {31'b0, complete}, 32'd0);
        chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_icache", icache_inst, 32'd0);
        chk("rst_addr", inst_addr, 32'd0);
        chk_en = 1'b1;

        // first fetch from the reset vector: 3-cycle latency
        pc = 32'hbfc0_0000; fetch_en = 1'b1;
        tick();
        chk("t1_req", {31'b0, inst_req}, 32'd1);
        chk("t1_addr", inst_addr, c_ADDR0);
        tick();
        chk("t1_c2", {31'b0, complete}, 32'd0);
        tick();
        chk("t1_c3", {31'b0, complete}, 32'd1);
        chk("t1_inst", icache_inst, 32'h3c08_0001);

        // back-to-back sequential fetch
        advance = 1'b1; fetch_en = 1'b0;
        tick();
        chk("t2_idle", {31'b0, complete}, 32'd0);
        advance = 1'b0; pc = 32'hbfc0_0004; fetch_en = 1'b1;
        tick();
        chk("t2_addr", inst_addr, c_ADDR4);
        run_until_done("t2_wait", 20);
        chk("t2_inst", icache_inst, 32'h2409_0002);

        // misaligned PC produces a bubble without touching the bus
        advance = 1'b1; fetch_en = 1'b0;
        tick();
        advance = 1'b0; pc = 32'hbfc0_0002; fetch_en = 1'b1;
        tick();
        chk("t5_complete", {31'b0, complete}, 32'd1);
        chk("t5_req", {31'b0, inst_req}, 32'd0);
        chk("t5_inst", icache_inst, 32'h0000_0000);

        // flush during the data phase, data arriving two cycles later
        advance = 1'b1; fetch_en = 1'b0;
        tick();
        advance = 1'b0; pc = 32'hbfc0_0100; fetch_en = 1'b1;
        data_lat = 2; rdata_ovr = 1'b1; rdata_val = 32'hdead_beef;
        tick();
        fetch_en = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("t3_complete", {31'b0, complete}, 32'd0);
        chk("t3_inst", icache_inst, 32'h0000_0000);
        rdata_ovr = 1'b0; data_lat = 0;
        pc = 32'hbfc0_0380; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        run_until_done("t3_wait", 20);
        chk("t3_inst2", icache_inst, 32'h8c0a_0000);

        // flush coincident with data_ok
        advance = 1'b1;
        tick();
        advance = 1'b0; pc = 32'hbfc0_0200; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4a_complete", {31'b0, complete}, 32'd0);
        tick();
        chk("t4a_complete2", {31'b0, complete}, 32'd0);

        // flush while the address waits three cycles for acceptance
        s_delay = 3; pc = 32'hbfc0_0300; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4b_req", {31'b0, inst_req}, 32'd1);
        chk("t4b_addr", inst_addr, map_addr(32'hbfc0_0300));
        tick();
        tick();
        chk("t4b_req_held", {31'b0, inst_req}, 32'd1);
        tick();
        tick();
        chk("t4b_complete", {31'b0, complete}, 32'd0);
        chk("t4b_inst", icache_inst, 32'h8c0a_0000);

        // asynchronous reset in the middle of the data phase
        data_lat = 3; pc = 32'hbfc0_0010; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        chk_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("t6_complete", {31'b0, complete}, 32'd0);
        chk("t6_req", {31'b0, inst_req}, 32'd0);
        chk("t6_inst", icache_inst, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_en = 1'b1;
        s_out = 1; s_ddelay = 0; rdata_ovr = 1'b1; rdata_val = 32'hffff_ffff;
        tick();
        rdata_ovr = 1'b0;
        chk("t6_spur_complete", {31'b0, complete}, 32'd0);
        chk("t6_spur_inst", icache_inst, 32'd0);

        // randomized traffic
        rnd_lat = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            advance = m_holding && ($urandom_range(2) == 0);
            flush = ($urandom_range(11) == 0);
            if (!m_busy_addr && !m_busy_data && !m_holding) begin
                case ($urandom_range(3))
                    0: pc = 32'hbfc0_0000;
                    1: pc = 32'h8000_0000;
                    2: pc = 32'h0040_0000;
                    default: pc = 32'hc000_0000;
                endcase
                pc = pc + 32'($urandom_range(255)) * 4;
                if ($urandom_range(5) == 0) pc = pc + 32'($urandom_range(1, 3));
                fetch_en = ($urandom_range(3) != 0);
            end
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_bridge.md
Name: ifetch_bridge

Overview:
Instruction-fetch bus bridge directly upstream of the IF stage register. Turns the current fetch PC into a single-outstanding SRAM-like instruction read, returns the instruction word, and raises `complete` when it is valid. Flushes (exception, branch, eret) cancel in-flight reads so stale data never reaches decode. Its `complete` and `icache_inst` outputs drive the IF stage's `complete` and `icache_inst` inputs.

Parameters:
- BUBBLE_INST, 32'h0000_0000, instruction word returned for a misaligned fetch (no bus access made).

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- pc  input  32  current fetch PC from the IF stage
- fetch_en  input  1  IF stage requests the instruction at `pc`
- advance  input  1  IF stage accepted `icache_inst` this cycle (pc_wren & ready & complete)
- flush  input  1  OR of exception, branch and eret flush
- complete  output  1  `icache_inst` is valid for the current `pc`
- icache_inst  output  32  fetched instruction
- inst_req  output  1  bus request valid
- inst_wr  output  1  constant 0
- inst_size  output  2  constant 2'b10 (word)
- inst_addr  output  32  bus address, held stable while `inst_req`=1
- inst_wdata  output  32  constant 0
- inst_addr_ok  input  1  bus accepted the address
- inst_data_ok  input  1  read data valid
- inst_rdata  input  32  read data

Behaviour:
- Reset values: state=IDLE, cancel=0, inst_buf=0, complete=0, icache_inst=0, inst_req=0, inst_addr=0.
- State machine states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - fetch_en & !flush & pc[1:0]==0 → latch inst_addr←pc, go to REQ.
  - fetch_en & !flush & pc[1:0]!=0 → inst_buf←BUBBLE_INST, go to DONE. No bus access is made.
  - Otherwise stay in IDLE.
- REQ:
  - inst_req=1.
  - inst_addr_ok → go to WAIT.
  - The request is never withdrawn once raised.
  - flush in REQ (or in the same cycle as addr_ok) sets cancel=1.
- WAIT:
  - inst_data_ok & !cancel & !flush → inst_buf←inst_rdata, go to DONE.
  - inst_data_ok & (cancel | flush) → discard the data, clear cancel, go to IDLE.
  - flush without data_ok → set cancel=1, stay in WAIT.
- DONE:
  - complete=1, icache_inst=inst_buf.
  - advance or flush → go to IDLE. complete is still 1 in that cycle, so the IF stage latches a bubble on flush.
  - Otherwise hold; inst_buf stays stable.
- complete=0 in every state other than DONE. icache_inst holds inst_buf in all states.
- Bus protocol:
  - inst_data_ok arrives at least one cycle after inst_addr_ok.
  - At most one transaction is outstanding.
  - data_ok while in IDLE/REQ/DONE is a protocol error and is ignored.
- Latency: aligned fetch with addr_ok in the first REQ cycle and data_ok one cycle later gives fetch_en-to-complete = 3 cycles. Misaligned fetch gives 1 cycle.
- Reset asserted mid-transaction returns all state to reset values immediately. The bus is reset concurrently.

Optional Feature:
- Macro: IFETCH_KSEG_MAP_EN.
- Defined: at launch, if pc[31:30]==2'b10 (kseg0/kseg1), inst_addr←{3'b000, pc[28:0]}; otherwise inst_addr←pc.
- Undefined: inst_addr←pc unchanged.
- Reset PC 32'hbfc00000 maps to 32'h1fc00000 when enabled.

Test Plan:
1. Reset release, pc=32'hbfc00000, fetch_en=1, addr_ok on the first REQ cycle, data_ok next cycle with rdata=32'h3c080001 → complete=1 exactly 3 cycles after fetch_en, icache_inst=32'h3c080001; inst_addr=32'hbfc00000 (32'h1fc00000 with IFETCH_KSEG_MAP_EN).
2. Back-to-back: advance in DONE, then pc=32'hbfc00004 → IDLE, new request at 32'hbfc00004; data 32'h24090002 delivered; no stale data shown.
3. flush pulsed in WAIT, data_ok two cycles later with rdata=32'hdeadbeef → complete never rises for it, return to IDLE; next fetch at 32'hbfc00380 returns its own data.
4. flush in the same cycle as data_ok → data discarded, complete=0; flush in REQ with addr_ok delayed 3 cycles → inst_req held with stable inst_addr, later data discarded.
5. pc=32'hbfc00002, fetch_en=1 → inst_req stays 0, complete=1 next cycle, icache_inst=BUBBLE_INST.
6. resetn pulsed low while in WAIT → complete=0, inst_req=0, icache_inst=0 asynchronously; a later data_ok in IDLE is ignored.
